// File: rtl/rtc_snapshot_master.sv
// MMIO initiator that reads CUR_DATE then CUR_TIME from the RTC and publishes them as one atomic snapshot.
// Define RTC_SNAPSHOT_INIT_EN to have it program INT_MASK and CTRL after reset.
module rtc_snapshot_master #(
  parameter logic [31:0] RTC_BASE       = 32'h8100_9000,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] INIT_CTRL      = 32'h0000_0001,
  parameter logic [31:0] INIT_MASK      = 32'h0000_000E
) (
  input  logic        rtc_clk,
  input  logic        resetn,
  input  logic        irq_in,
  output logic        eoi_out,
  input  logic        snap_req,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic [31:0] snap_date,
  output logic [31:0] snap_time,
  output logic        snap_valid,
  output logic        snap_from_irq,
  output logic        busy,
  output logic        err,
  input  logic        err_clr
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_DATE, S_GAP1, S_RD_TIME, S_PUBLISH, S_EOI, S_EOI_HOLD
`ifdef RTC_SNAPSHOT_INIT_EN
    , S_GAP0, S_INIT_MASK, S_INIT_CTRL
`endif
  } state_t;

`ifdef RTC_SNAPSHOT_INIT_EN
  localparam state_t S_RESET = S_INIT_MASK;
`else
  localparam state_t S_RESET = S_IDLE;
`endif

  state_t          state, state_n;
  logic            src, src_n;
  logic            req_pending, req_clr;
  logic [TW-1:0]   tcnt;
  logic            gap_cnt;
  logic [31:0]     date_tmp;
  logic            tx_done, tx_to, in_gap, tx_state, start_tx;
  logic [31:0]     tx_addr, tx_wdata;
  logic [3:0]      tx_wstrb;
`ifdef RTC_SNAPSHOT_INIT_EN
  logic            ctrl_done;
`endif

  assign mem_instr = 1'b0;
  assign busy      = (state != S_IDLE);
  // mem_valid is only ever high inside a transaction state, so ready is ignored elsewhere
  assign tx_done   = mem_valid & mem_ready;
  assign tx_to     = mem_valid & ~mem_ready & (tcnt == TLAST);

  always_comb begin
    state_n  = state;
    src_n    = src;
    req_clr  = 1'b0;
    in_gap   = 1'b0;
    tx_state = 1'b0;
    tx_addr  = RTC_BASE;
    tx_wdata = 32'h0;
    tx_wstrb = 4'h0;
    case (state)
      S_IDLE: begin
        if (irq_in) begin
          state_n = S_RD_DATE;
          src_n   = 1'b1;
        end else if (req_pending) begin
          state_n = S_RD_DATE;
          src_n   = 1'b0;
          req_clr = 1'b1;
        end
      end
      S_RD_DATE: begin
        if (tx_done)    state_n = S_GAP1;
        else if (tx_to) state_n = src ? S_EOI : S_IDLE;
      end
      S_GAP1: begin
        in_gap = 1'b1;
        if (gap_cnt) state_n = S_RD_TIME;
      end
      S_RD_TIME: begin
        if (tx_done)    state_n = S_PUBLISH;
        else if (tx_to) state_n = src ? S_EOI : S_IDLE;
      end
      S_PUBLISH:  state_n = src ? S_EOI : S_IDLE;
      S_EOI:      state_n = S_EOI_HOLD;
      S_EOI_HOLD: state_n = S_IDLE;
`ifdef RTC_SNAPSHOT_INIT_EN
      S_INIT_MASK: begin
        if (tx_done)    state_n = S_GAP0;
        else if (tx_to) state_n = S_IDLE;
      end
      S_GAP0: begin
        in_gap = 1'b1;
        if (gap_cnt) state_n = ctrl_done ? S_IDLE : S_INIT_CTRL;
      end
      S_INIT_CTRL: begin
        if (tx_done)    state_n = S_GAP0;
        else if (tx_to) state_n = S_IDLE;
      end
`endif
      default: state_n = S_IDLE;
    endcase

    case (state_n)
      S_RD_DATE: begin
        tx_state = 1'b1;
        tx_addr  = RTC_BASE + 32'h14;
      end
      S_RD_TIME: begin
        tx_state = 1'b1;
        tx_addr  = RTC_BASE + 32'h18;
      end
`ifdef RTC_SNAPSHOT_INIT_EN
      S_INIT_MASK: begin
        tx_state = 1'b1;
        tx_addr  = RTC_BASE + 32'h1C;
        tx_wdata = INIT_MASK;
        tx_wstrb = 4'hF;
      end
      S_INIT_CTRL: begin
        tx_state = 1'b1;
        tx_addr  = RTC_BASE;
        tx_wdata = INIT_CTRL;
        tx_wstrb = 4'hF;
      end
`endif
      default: ;
    endcase
    // valid is low in a transaction state only on the first cycle out of reset
    start_tx = tx_state && ((state_n != state) || !mem_valid);
  end

  always_ff @(posedge rtc_clk) begin
    if (!resetn) begin
      state         <= S_RESET;
      src           <= 1'b0;
      req_pending   <= 1'b0;
      tcnt          <= '0;
      gap_cnt       <= 1'b0;
      date_tmp      <= 32'h0;
      mem_valid     <= 1'b0;
      mem_addr      <= 32'h0;
      mem_wdata     <= 32'h0;
      mem_wstrb     <= 4'h0;
      eoi_out       <= 1'b0;
      snap_valid    <= 1'b0;
      snap_date     <= 32'h2026_0101;
      snap_time     <= 32'h0;
      snap_from_irq <= 1'b0;
      err           <= 1'b0;
`ifdef RTC_SNAPSHOT_INIT_EN
      ctrl_done     <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      src         <= src_n;
      req_pending <= (req_pending & ~req_clr) | snap_req;
      gap_cnt     <= in_gap ? ~gap_cnt : 1'b0;
      eoi_out     <= (state_n == S_EOI);
      snap_valid  <= 1'b0;

      if (start_tx) begin
        mem_valid <= 1'b1;
        mem_addr  <= tx_addr;
        mem_wdata <= tx_wdata;
        mem_wstrb <= tx_wstrb;
        tcnt      <= '0;
      end else if (tx_done || tx_to) begin
        mem_valid <= 1'b0;
      end else if (mem_valid) begin
        tcnt <= tcnt + 1'b1;
      end

      if (tx_done && state == S_RD_DATE) date_tmp <= mem_rdata;
      // both words land on the same edge, so consumers never see a half-updated pair
      if (tx_done && state == S_RD_TIME) begin
        snap_date     <= date_tmp;
        snap_time     <= mem_rdata;
        snap_from_irq <= src;
        snap_valid    <= 1'b1;
      end

      if (tx_to) begin
        date_tmp <= 32'h0;
        err      <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
`ifdef RTC_SNAPSHOT_INIT_EN
      if (tx_done && state == S_INIT_CTRL) ctrl_done <= 1'b1;
`endif
    end
  end

endmodule
